efi_crank_sched: RTL and testbench

- Crank-angle engine controller for a 60-2 toothed crank wheel with a VR sensor.
- Digitises the VR tooth stream, measures tooth periods and detects the missing-tooth gap to acquire sync.
- Tracks tooth index and a two-revolution phase bit.
- Schedules four ignition coil dwell/spark outputs and two sequential-pair injector pulses.
- Sits between the VR conditioning front end and the coil/injector driver pins.

---
 rtl/efi_crank_sched_if.sv | 19 +
 rtl/efi_crank_sched.sv | 130 +++++++++++++
 tb/tb_efi_crank_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/efi_crank_sched_if.sv
// efi_crank_sched_if: crank wheel input and coil/injector/sync outputs of efi_crank_sched
// Signals:
//   i_vrin                  digitised VR tooth signal (rising edge = tooth)
//   o_ign_a .. o_ign_d      coil dwell outputs (high = charging, falling edge = spark)
//   o_inj_a, o_inj_b        injector bank open outputs
//   o_synced                crank position locked
// Modports: master drives the tooth stream (front end / bench), slave is the scheduler.
interface efi_crank_sched_if;
    logic i_vrin;
    logic o_ign_a;
    logic o_ign_b;
    logic o_ign_c;
    logic o_ign_d;
    logic o_inj_a;
    logic o_inj_b;
    logic o_synced;
    modport master (output i_vrin, input o_ign_a, o_ign_b, o_ign_c, o_ign_d, o_inj_a, o_inj_b, o_synced);
    modport slave (input i_vrin, output o_ign_a, o_ign_b, o_ign_c, o_ign_d, o_inj_a, o_inj_b, o_synced);
endinterface

// File: rtl/efi_crank_sched.sv
// efi_crank_sched: 60-2 crank wheel decoder with four-coil ignition and paired injector scheduling
// Ports:
//   clk    system clock (2 MHz nominal)
//   reset  asynchronous active-high reset
//   bus    efi_crank_sched_if.slave: i_vrin in, o_ign_a..d / o_inj_a..b / o_synced out
// Optional: define VR_FILTER_EN to add a FILTER_CYCLES-long glitch filter after the synchroniser.
module efi_crank_sched #(
    parameter int SPARK_TOOTH = 20,
    parameter int DWELL_TEETH = 4,
    parameter int INJ_TOOTH   = 0,
    parameter int INJ_PW      = 4000,
    parameter int PERIOD_W    = 20
`ifdef VR_FILTER_EN
    ,parameter int FILTER_CYCLES = 8
`endif
) (
    input logic clk,
    input logic reset,
    efi_crank_sched_if.slave bus
);
    localparam logic [5:0]  LAST    = 6'd57;
    localparam logic [5:0]  A_LO    = 6'(SPARK_TOOTH - DWELL_TEETH);
    localparam logic [5:0]  A_HI    = 6'(SPARK_TOOTH - 1);
    localparam logic [5:0]  B_LO    = 6'(SPARK_TOOTH - DWELL_TEETH + 30);
    localparam logic [5:0]  B_HI    = 6'(SPARK_TOOTH + 29);
    localparam logic [5:0]  INJ_IDX = 6'(INJ_TOOTH);
    localparam logic [15:0] PW      = 16'(INJ_PW);
    typedef enum logic {ST_HUNT, ST_LOCK} state_t;
    state_t r_state, w_nstate;
    logic [1:0] r_sync;
    logic r_last, r_tooth, w_lvl;
    logic [PERIOD_W-1:0] r_cnt, r_prev_per;
    logic [1:0] r_nev;
    logic [5:0] r_idx, w_nidx;
    logic r_phase, w_nph;
    logic r_ign_a, r_ign_b, r_ign_c, r_ign_d, r_inj_a, r_inj_b;
    logic [15:0] r_icnt;
    logic w_stall, w_gap, w_lock, w_win_a, w_win_b, w_load;
`ifdef VR_FILTER_EN
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
    logic r_filt;
    logic [FW-1:0] r_fcnt;
    // the filtered level only follows a new level that has been stable for FILTER_CYCLES clocks
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (r_sync[1] == r_filt) r_fcnt <= '0;
        else if (r_fcnt == F_LAST) begin
            r_filt <= r_sync[1];
            r_fcnt <= '0;
        end else r_fcnt <= r_fcnt + 1'b1;
    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync[1];
`endif
    assign w_stall = &r_cnt;
    // ratio test cur > 1.5*prev, one bit wider so the sum cannot wrap; needs cur and prev both real periods
    assign w_gap = r_tooth && r_nev == 2'd2 &&
                   ({1'b0, r_cnt} > {1'b0, r_prev_per} + {2'b0, r_prev_per[PERIOD_W-1:1]});
    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx;
        w_nph    = r_phase;
        if (w_stall) w_nstate = ST_HUNT;
        else if (r_tooth) begin
            if (r_state == ST_HUNT) begin
                if (w_gap) begin
                    w_nstate = ST_LOCK;
                    w_nidx   = '0;
                    w_nph    = 1'b0;
                end
            end else if (w_gap ^ (r_idx == LAST)) w_nstate = ST_HUNT;
            else begin
                w_nidx = w_gap ? 6'd0 : r_idx + 6'd1;
                w_nph  = r_phase ^ w_gap;
            end
        end
    end
    assign w_lock  = w_nstate == ST_LOCK;
    assign w_win_a = w_nidx >= A_LO && w_nidx <= A_HI;
    assign w_win_b = w_nidx >= B_LO && w_nidx <= B_HI;
    assign w_load  = w_lock && r_tooth && w_nidx == INJ_IDX;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_sync     <= '0;
            r_last     <= 1'b0;
            r_tooth    <= 1'b0;
            r_cnt      <= '0;
            r_prev_per <= '0;
            r_nev      <= '0;
            r_state    <= ST_HUNT;
            r_idx      <= '0;
            r_phase    <= 1'b0;
            r_ign_a    <= 1'b0;
            r_ign_b    <= 1'b0;
            r_ign_c    <= 1'b0;
            r_ign_d    <= 1'b0;
            r_icnt     <= '0;
            r_inj_a    <= 1'b0;
            r_inj_b    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], bus.i_vrin};
            r_last     <= w_lvl;
            r_tooth    <= w_lvl & ~r_last;
            r_cnt      <= r_tooth ? PERIOD_W'(1) : (w_stall ? r_cnt : r_cnt + 1'b1);
            r_prev_per <= r_tooth ? r_cnt : r_prev_per;
            // a stall voids the period history; a tooth ending a stall counts as the first edge again
            r_nev      <= r_tooth ? (w_stall ? 2'd1 : (r_nev == 2'd2 ? 2'd2 : r_nev + 2'd1))
                                  : (w_stall ? 2'd0 : r_nev);
            r_state    <= w_nstate;
            r_idx      <= w_nidx;
            r_phase    <= w_nph;
            r_ign_a    <= w_lock & ~w_nph & w_win_a;
            r_ign_b    <= w_lock & ~w_nph & w_win_b;
            r_ign_c    <= w_lock & w_nph & w_win_a;
            r_ign_d    <= w_lock & w_nph & w_win_b;
            r_icnt     <= !w_lock ? 16'd0 : w_load ? PW : (r_icnt > 16'd1 ? r_icnt - 16'd1 : 16'd0);
            r_inj_a    <= w_lock && (w_load ? (PW != 16'd0 && !w_nph) : (r_inj_a && r_icnt > 16'd1));
            r_inj_b    <= w_lock && (w_load ? (PW != 16'd0 && w_nph) : (r_inj_b && r_icnt > 16'd1));
        end
    assign bus.o_synced = r_state == ST_LOCK;
    assign bus.o_ign_a  = r_ign_a;
    assign bus.o_ign_b  = r_ign_b;
    assign bus.o_ign_c  = r_ign_c;
    assign bus.o_ign_d  = r_ign_d;
    assign bus.o_inj_a  = r_inj_a;
    assign bus.o_inj_b  = r_inj_b;
endmodule

// File: tb/tb_efi_crank_sched.sv
// tb_efi_crank_sched: wheel-segment table plus tooth-level reference model for efi_crank_sched
module tb_efi_crank_sched;
    localparam int SPARK = 20;
    localparam int DWELL = 4;
    localparam int INJT  = 0;
    localparam int PW    = 300;
    localparam int PERW  = 12;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vrin = 1'b0;
    int n_pass = 0;
    int n_tot = 0;
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    efi_crank_sched_if bus();
    efi_crank_sched_if bus0();
    assign bus.i_vrin  = vrin;
    assign bus0.i_vrin = vrin;
    efi_crank_sched #(.SPARK_TOOTH(SPARK), .DWELL_TEETH(DWELL), .INJ_TOOTH(INJT), .INJ_PW(PW), .PERIOD_W(PERW))
        u_dut (.clk(clk), .reset(reset), .bus(bus));
    efi_crank_sched #(.SPARK_TOOTH(SPARK), .DWELL_TEETH(DWELL), .INJ_TOOTH(INJT), .INJ_PW(0), .PERIOD_W(PERW))
        u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    int w_run = 0;
    int w_last = 0;
    int w_seq = 0;
    int w_seen = 0;
    always @(negedge clk)
        if (bus.o_inj_a | bus.o_inj_b) w_run <= w_run + 1;
        else begin
            if (w_run > 0 && bus.o_synced) begin
                w_last <= w_run;
                w_seq  <= w_seq + 1;
            end
            w_run <= 0;
        end
    bit m_sync, m_ph, m_have, m_inj_on, m_bank;
    int m_idx, m_last, m_prev_iv, m_cur_iv, m_niv, m_load;
    typedef struct {
        int n;
        int per;
        int accel;
        int gmul;
        bit rnd;
        bit exp_sync;
    } seg_t;
    seg_t tbl[17];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    endtask
    task automatic model_clear();
        m_sync = 0;
        m_ph = 0;
        m_idx = 0;
        m_have = 0;
        m_niv = 0;
        m_inj_on = 0;
    endtask
    task automatic model_edge();
        bit gap;
        if (m_have) begin
            m_prev_iv = m_cur_iv;
            m_cur_iv = cyc - m_last;
            if (m_niv < 2) m_niv++;
        end
        m_have = 1;
        m_last = cyc;
        gap = m_niv >= 2 && m_cur_iv * 2 > m_prev_iv * 3;
        if (!m_sync) begin
            if (gap) begin
                m_sync = 1;
                m_idx = 0;
                m_ph = 0;
            end
        end else if (gap) begin
            if (m_idx == 57) begin
                m_idx = 0;
                m_ph = !m_ph;
            end else m_sync = 0;
        end else if (m_idx == 57) m_sync = 0;
        else m_idx++;
        if (!m_sync) m_inj_on = 0;
        else if (m_idx == INJT) begin
            m_inj_on = PW > 0;
            m_bank = m_ph;
            m_load = cyc;
        end
    endtask
    function automatic logic [3:0] exp_ign();
        bit a = m_idx >= SPARK - DWELL && m_idx <= SPARK - 1;
        bit b = m_idx >= SPARK - DWELL + 30 && m_idx <= SPARK + 29;
        return m_sync ? {a & !m_ph, b & !m_ph, a & m_ph, b & m_ph} : 4'b0;
    endfunction
    function automatic logic [1:0] exp_inj();
        bit on = m_sync && m_inj_on && (cyc - m_load) < PW;
        return {on & !m_bank, on & m_bank};
    endfunction
    task automatic check_all();
        chk("synced", bus.o_synced, m_sync);
        chk("ign", {bus.o_ign_a, bus.o_ign_b, bus.o_ign_c, bus.o_ign_d}, exp_ign());
        chk("inj", {bus.o_inj_a, bus.o_inj_b}, exp_inj());
        chk("inj_pw0", {bus0.o_inj_a, bus0.o_inj_b}, 0);
        if (w_seq != w_seen) begin
            w_seen = w_seq;
            chk("inj_width", w_last, PW);
        end
    endtask
    task automatic pulse(input int per);
        vrin = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("latency", bus.o_synced, m_sync);
        @(posedge clk);
        #1 model_edge();
        check_all();
        repeat (17) @(negedge clk);
        vrin = 1'b0;
        repeat (per - 20) @(negedge clk);
    endtask
    task automatic run_seg(input int n, input int per, input int accel, input int gmul, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int p = per + accel * i + (rnd ? int'($urandom_range(8)) - 4 : 0);
            if (gmul > 0 && i == n - 1) p = gmul * (per + accel * i);
            pulse(p);
        end
    endtask
    initial begin
        tbl[0] = '{57, 40, 0, 3, 0, 0};
        for (int i = 1; i <= 6; i++) tbl[i] = '{58, 40, 0, 3, 0, 1};
        tbl[7]  = '{12, 40, 0, 3, 0, 1};
        tbl[8]  = '{58, 40, 0, 3, 0, 0};
        tbl[9]  = '{58, 40, 0, 3, 0, 1};
        tbl[10] = '{82, 40, 0, 3, 0, 0};
        tbl[11] = '{58, 40, 0, 3, 0, 1};
        tbl[12] = '{58, 40, 1, 5, 0, 1};
        tbl[13] = '{58, 40, 1, 5, 0, 1};
        for (int i = 14; i <= 16; i++) tbl[i] = '{58, 40, 0, 3, 1, 1};
        model_clear();
        repeat (10) @(negedge clk);
        chk("rst_synced", bus.o_synced, 0);
        chk("rst_outs", {bus.o_ign_a, bus.o_ign_b, bus.o_ign_c, bus.o_ign_d, bus.o_inj_a, bus.o_inj_b}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            run_seg(tbl[i].n, tbl[i].per, tbl[i].accel, tbl[i].gmul, tbl[i].rnd);
            chk($sformatf("seg%0d_sync", i), bus.o_synced, tbl[i].exp_sync);
        end
        run_seg(18, 40, 0, 0, 0);
        repeat (5000) @(negedge clk);
        chk("stall_sync", bus.o_synced, 0);
        chk("stall_outs", {bus.o_ign_a, bus.o_ign_b, bus.o_ign_c, bus.o_ign_d, bus.o_inj_a, bus.o_inj_b}, 0);
        model_clear();
        run_seg(57, 40, 0, 3, 0);
        run_seg(18, 40, 0, 0, 0);
        chk("dwell_before_rst", bus.o_ign_a, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("async_rst_ign", {bus.o_ign_a, bus.o_ign_b, bus.o_ign_c, bus.o_ign_d}, 0);
        chk("async_rst_sync", bus.o_synced, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
